// File: rtl/shift_reg_unload.sv
// rtl/shift_reg_unload.sv - parallel-in / serial-out word unloader, negedge domain, optional parity (SHIFT_REG_UNLOAD_PARITY_EN)
module shift_reg_unload #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CHUNK-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef SHIFT_REG_UNLOAD_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    count;
  logic             valid_q;
  logic             last_q;
  logic             load;

`ifdef SHIFT_REG_UNLOAD_PARITY_EN
  logic             parity_q;
  assign out_parity = parity_q;
`endif

  // The bottom chunk of the shift register is always the one on the wire.
  assign out_valid = valid_q;
  assign out_data  = sreg[CHUNK-1:0];
  assign out_last  = last_q;
  assign busy      = (state == SEND);

  // Ready in IDLE, or while the final chunk of the current word is being taken,
  // which lets the next word follow with no bubble.
  assign in_ready = !rst && ((state == IDLE) || ((state == SEND) && last_q && out_ready));
  assign load     = in_valid && in_ready;

  // Single FSM: load a word, shift one chunk per downstream transfer, then reload or idle.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef SHIFT_REG_UNLOAD_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (load) begin
      state    <= SEND;
      sreg     <= in_data;
      count    <= CW'(NCHUNK - 1);
      valid_q  <= 1'b1;
      last_q   <= (NCHUNK == 1);
`ifdef SHIFT_REG_UNLOAD_PARITY_EN
      parity_q <= ^in_data;
`endif
    end else if ((state == SEND) && out_ready) begin
      if (!last_q) begin
        sreg   <= sreg >> CHUNK;
        count  <= count - CW'(1);
        last_q <= (count == CW'(1));
      end else begin
        state    <= IDLE;
        sreg     <= '0;
        count    <= '0;
        valid_q  <= 1'b0;
        last_q   <= 1'b0;
`ifdef SHIFT_REG_UNLOAD_PARITY_EN
        parity_q <= 1'b0;
`endif
      end
    end
  end

endmodule
